// File: rtl/prefetch_pkg.sv
// Shared types and constants for the next-line prefetcher and its queue.
package prefetch_pkg;

   localparam int PF_ADDR_W = 40;

   localparam logic [4:0] M_PFR = 5'b00010;
   localparam logic [4:0] M_PFW = 5'b00011;

   localparam logic [PF_ADDR_W-1:0] CACHEABLE_BASE  = 40'h00_8000_0000;
   localparam logic [PF_ADDR_W-1:0] CACHEABLE_LIMIT = 40'h01_8000_0000;

   typedef struct packed {
      logic [PF_ADDR_W-1:0] addr;
      logic [4:0]           cmd;
   } pf_entry_t;

   typedef enum logic {
      GEN_IDLE,
      GEN_RUN
   } gen_state_t;

   function automatic logic isCacheable(input logic [PF_ADDR_W-1:0] addr);
      return (addr >= CACHEABLE_BASE) && (addr < CACHEABLE_LIMIT);
   endfunction

endpackage

// File: rtl/pf_fifo.sv
// Small pending-prefetch queue; a push is still taken when full if the
// head is popped in the same cycle.
module pf_fifo
   import prefetch_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = pf_entry_t
) (
   input  logic clock,
   input  logic reset,
   input  logic flush,
   input  logic push,
   input  T     pushData,
   input  logic pop,
   output T     headData,
   output logic full,
   output logic empty
);

   localparam int PTR_W = $clog2(DEPTH);

   T                 mem [DEPTH];
   logic [PTR_W:0]   wrPtr;
   logic [PTR_W:0]   rdPtr;
   logic             doPush;
   logic             doPop;

   assign empty    = (wrPtr == rdPtr);
   assign full     = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                     (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
   assign doPop    = pop && !empty;
   assign doPush   = push && (!full || doPop);
   assign headData = mem[rdPtr[PTR_W-1:0]];

   // Pointers carry one extra wrap bit so full and empty can be told apart
   // without a separate occupancy counter; a flush simply realigns them.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else if (flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + (PTR_W+1)'(1);
         if (doPop)  rdPtr <= rdPtr + (PTR_W+1)'(1);
      end
   end

   // Storage is cleared on reset so the head (and thus the outgoing address
   // and command) reads as zero straight out of reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (doPush && !flush) begin
         mem[wrPtr[PTR_W-1:0]] <= pushData;
      end
   end

endmodule

// File: rtl/multi_line_prefetcher.sv
// Degree-N next-line prefetcher: turns a miss trigger into a run of
// sequential line addresses (page- and window-clipped) queued for the MSHRs.
module multi_line_prefetcher
   import prefetch_pkg::*;
#(
   parameter  int ADDR_W     = PF_ADDR_W,
   parameter  int LINE_BYTES = 64,
   parameter  int PAGE_BYTES = 4096,
   parameter  int MAX_DEGREE = 4,
   parameter  int QDEPTH     = 4,
   localparam int DEG_W      = $clog2(MAX_DEGREE + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DEG_W-1:0]  io_degree,
   input  logic              io_flush,
   input  logic              io_mshr_avail,
   input  logic              io_req_val,
   input  logic [ADDR_W-1:0] io_req_addr,
   input  logic [1:0]        io_req_coh_state,
   input  logic              io_prefetch_ready,
   output logic              io_prefetch_valid,
   output logic [4:0]        io_prefetch_bits_uop_mem_cmd,
   output logic [ADDR_W-1:0] io_prefetch_bits_addr
);

   localparam int                LINE_OFF  = $clog2(LINE_BYTES);
   localparam int                PAGE_OFF  = $clog2(PAGE_BYTES);
   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LINE_BYTES);

   gen_state_t        state;
   gen_state_t        stateNext;
   logic [ADDR_W-1:0] curLine;
   logic [ADDR_W-1:0] curLineNext;
   logic [DEG_W-1:0]  remaining;
   logic [DEG_W-1:0]  remainingNext;
   logic [4:0]        seqCmd;
   logic [4:0]        seqCmdNext;
   logic [ADDR_W-1:0] lastTrig;
   logic [ADDR_W-1:0] lastTrigNext;
   logic              lastTrigValid;
   logic              lastTrigValidNext;

   logic [ADDR_W-1:0] reqLine;
   logic [DEG_W-1:0]  degreeClamped;
   logic              trigAccept;
   logic              candInRange;
   logic              popFire;
   logic              fifoPush;
   logic              fifoFull;
   logic              fifoEmpty;
   pf_entry_t         pushEntry;
   pf_entry_t         headEntry;
   logic              unusedBits;

   assign reqLine       = {io_req_addr[ADDR_W-1:LINE_OFF], {LINE_OFF{1'b0}}};
   assign degreeClamped = (io_degree > DEG_W'(MAX_DEGREE)) ? DEG_W'(MAX_DEGREE) : io_degree;
   assign trigAccept    = io_req_val && (io_degree != '0) && !io_flush &&
                          (!lastTrigValid || (reqLine != lastTrig));
   assign candInRange   = (curLine[ADDR_W-1:PAGE_OFF] == lastTrig[ADDR_W-1:PAGE_OFF]) &&
                          isCacheable(curLine);

   assign io_prefetch_valid            = !fifoEmpty && io_mshr_avail;
   assign popFire                      = io_prefetch_valid && io_prefetch_ready;
   assign io_prefetch_bits_addr        = headEntry.addr;
   assign io_prefetch_bits_uop_mem_cmd = headEntry.cmd;

   assign pushEntry.addr = curLine;
   assign pushEntry.cmd  = seqCmd;

   assign unusedBits = ^{io_req_coh_state[0], io_req_addr[LINE_OFF-1:0]};

   // Generator registers: the FSM state, the next candidate line, how many
   // lines are still owed for this trigger, and the last accepted trigger
   // line used to filter repeated misses to the same line.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= GEN_IDLE;
         curLine       <= '0;
         remaining     <= '0;
         seqCmd        <= '0;
         lastTrig      <= '0;
         lastTrigValid <= 1'b0;
      end else begin
         state         <= stateNext;
         curLine       <= curLineNext;
         remaining     <= remainingNext;
         seqCmd        <= seqCmdNext;
         lastTrig      <= lastTrigNext;
         lastTrigValid <= lastTrigValidNext;
      end
   end

   // Next-state logic. Flush wins over everything and forgets the last
   // trigger. A fresh trigger restarts the sequence even mid-run (already
   // queued lines stay). Otherwise, while running, push one line per cycle
   // until the count runs out or the candidate leaves the trigger's page or
   // the cacheable window; a full queue with no pop just holds the candidate.
   always_comb begin
      stateNext         = state;
      curLineNext       = curLine;
      remainingNext     = remaining;
      seqCmdNext        = seqCmd;
      lastTrigNext      = lastTrig;
      lastTrigValidNext = lastTrigValid;
      fifoPush          = 1'b0;
      if (io_flush) begin
         stateNext         = GEN_IDLE;
         lastTrigValidNext = 1'b0;
      end else if (trigAccept) begin
         stateNext         = GEN_RUN;
         lastTrigNext      = reqLine;
         lastTrigValidNext = 1'b1;
         curLineNext       = reqLine + LINE_STEP;
         remainingNext     = degreeClamped;
         seqCmdNext        = {4'b0001, io_req_coh_state[1]};
      end else if (state == GEN_RUN) begin
         if (!candInRange) begin
            stateNext = GEN_IDLE;
         end else if (!fifoFull || popFire) begin
            fifoPush      = 1'b1;
            curLineNext   = curLine + LINE_STEP;
            remainingNext = remaining - DEG_W'(1);
            if (remaining == DEG_W'(1)) stateNext = GEN_IDLE;
         end
      end
   end

   pf_fifo #(
      .DEPTH (QDEPTH),
      .T     (pf_entry_t)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .flush    (io_flush),
      .push     (fifoPush),
      .pushData (pushEntry),
      .pop      (popFire),
      .headData (headEntry),
      .full     (fifoFull),
      .empty    (fifoEmpty)
   );

endmodule

// File: tb/tb_multi_line_prefetcher.sv
// Bench for multi_line_prefetcher: directed scenarios followed by random
// triggers scored against a transaction-level model of the issued lines.
module tb_multi_line_prefetcher;

   localparam int               ADDR_W     = 40;
   localparam int               MAX_DEGREE = 4;
   localparam logic [39:0]      WIN_BASE   = 40'h00_8000_0000;
   localparam logic [39:0]      WIN_LIMIT  = 40'h01_8000_0000;
   localparam logic [4:0]       CMD_READ   = 5'b00010;
   localparam logic [4:0]       CMD_WRITE  = 5'b00011;

   typedef struct {
      logic [39:0] addr;
      logic [4:0]  cmd;
   } expect_t;

   logic              clock = 1'b0;
   logic              reset;
   logic [2:0]        io_degree;
   logic              io_flush;
   logic              io_mshr_avail;
   logic              io_req_val;
   logic [ADDR_W-1:0] io_req_addr;
   logic [1:0]        io_req_coh_state;
   logic              io_prefetch_ready;
   logic              io_prefetch_valid;
   logic [4:0]        io_prefetch_bits_uop_mem_cmd;
   logic [ADDR_W-1:0] io_prefetch_bits_addr;

   int          asserts  = 0;
   int          failures = 0;
   expect_t     expQ[$];
   logic [39:0] mLastTrig;
   logic        mLastValid;

   always #5 clock = ~clock;

   multi_line_prefetcher dut (
      .clock                        (clock),
      .reset                        (reset),
      .io_degree                    (io_degree),
      .io_flush                     (io_flush),
      .io_mshr_avail                (io_mshr_avail),
      .io_req_val                   (io_req_val),
      .io_req_addr                  (io_req_addr),
      .io_req_coh_state             (io_req_coh_state),
      .io_prefetch_ready            (io_prefetch_ready),
      .io_prefetch_valid            (io_prefetch_valid),
      .io_prefetch_bits_uop_mem_cmd (io_prefetch_bits_uop_mem_cmd),
      .io_prefetch_bits_addr        (io_prefetch_bits_addr)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      asserts++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic val, input logic [39:0] addr, input logic [1:0] coh);
      io_req_val       = val;
      io_req_addr      = addr;
      io_req_coh_state = coh;
   endtask

   task automatic trigger(input logic [39:0] addr, input logic [1:0] coh);
      applyStimulus(1'b1, addr, coh);
      tick();
      applyStimulus(1'b0, 40'd0, 2'd0);
   endtask

   task automatic expectIssue(input string tag, input logic [39:0] addr, input logic [4:0] cmd);
      #1;
      checkOutput({tag, "/valid"}, 64'(io_prefetch_valid), 64'd1);
      checkOutput({tag, "/addr"}, 64'(io_prefetch_bits_addr), 64'(addr));
      checkOutput({tag, "/cmd"}, 64'(io_prefetch_bits_uop_mem_cmd), 64'(cmd));
      tick();
   endtask

   task automatic expectIdle(input string tag);
      #1;
      checkOutput({tag, "/valid"}, 64'(io_prefetch_valid), 64'd0);
      tick();
   endtask

   // Model: the lines a trigger should produce, from line/page/window arithmetic.
   task automatic buildExpected(input logic [39:0] addr, input int deg, input logic [1:0] coh);
      logic [39:0] line;
      logic [39:0] cand;
      int          n;
      expect_t     e;
      line = {addr[39:6], 6'b0};
      n    = (deg > MAX_DEGREE) ? MAX_DEGREE : deg;
      for (int i = 1; i <= n; i++) begin
         cand = line + 40'(i * 64);
         if (cand[39:12] != line[39:12]) break;
         if (cand < WIN_BASE || cand >= WIN_LIMIT) break;
         e.addr = cand;
         e.cmd  = coh[1] ? CMD_WRITE : CMD_READ;
         expQ.push_back(e);
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [39:0] addr;
      logic [39:0] line;
      logic [39:0] heldAddr;
      logic [1:0]  coh;
      int          deg;
      int          kind;
      int          idle;
      bit          holdPending;
      bit          done;

      reset             = 1'b1;
      io_degree         = 3'd0;
      io_flush          = 1'b0;
      io_mshr_avail     = 1'b1;
      io_prefetch_ready = 1'b1;
      applyStimulus(1'b0, 40'd0, 2'd0);
      #3;
      checkOutput("reset/valid", 64'(io_prefetch_valid), 64'd0);
      checkOutput("reset/addr", 64'(io_prefetch_bits_addr), 64'd0);
      checkOutput("reset/cmd", 64'(io_prefetch_bits_uop_mem_cmd), 64'd0);
      tick();
      reset = 1'b0;
      tick();

      $display("[TB] basic degree-4 run");
      io_degree = 3'd4;
      trigger(40'h00_8000_1010, 2'b00);
      expectIdle("t1_lat");
      expectIssue("t1_0", 40'h00_8000_1040, CMD_READ);
      expectIssue("t1_1", 40'h00_8000_1080, CMD_READ);
      expectIssue("t1_2", 40'h00_8000_10C0, CMD_READ);
      expectIssue("t1_3", 40'h00_8000_1100, CMD_READ);
      expectIdle("t1_end");
      expectIdle("t1_end2");

      $display("[TB] page clip");
      trigger(40'h00_8000_1F80, 2'b00);
      expectIdle("t2_lat");
      expectIssue("t2_0", 40'h00_8000_1FC0, CMD_READ);
      for (int i = 0; i < 3; i++) expectIdle("t2_end");

      $display("[TB] window clip and write command");
      trigger(40'h01_7FFF_FFC0, 2'b10);
      for (int i = 0; i < 4; i++) expectIdle("t3_top");
      trigger(40'h00_8000_0000, 2'b10);
      expectIdle("t3_lat");
      expectIssue("t3_0", 40'h00_8000_0040, CMD_WRITE);
      expectIssue("t3_1", 40'h00_8000_0080, CMD_WRITE);
      expectIssue("t3_2", 40'h00_8000_00C0, CMD_WRITE);
      expectIssue("t3_3", 40'h00_8000_0100, CMD_WRITE);
      expectIdle("t3_end");

      $display("[TB] degree clamp, late change, disabled");
      io_degree = 3'd7;
      trigger(40'h00_8000_4000, 2'b01);
      io_degree = 3'd1;
      expectIdle("tc_lat");
      expectIssue("tc_0", 40'h00_8000_4040, CMD_READ);
      expectIssue("tc_1", 40'h00_8000_4080, CMD_READ);
      expectIssue("tc_2", 40'h00_8000_40C0, CMD_READ);
      expectIssue("tc_3", 40'h00_8000_4100, CMD_READ);
      expectIdle("tc_end");
      io_degree = 3'd0;
      trigger(40'h00_8000_4800, 2'b00);
      for (int i = 0; i < 3; i++) expectIdle("tc_off");
      io_degree = 3'd2;
      trigger(40'h00_8000_4800, 2'b00);
      expectIdle("tc2_lat");
      expectIssue("tc2_0", 40'h00_8000_4840, CMD_READ);
      expectIssue("tc2_1", 40'h00_8000_4880, CMD_READ);
      expectIdle("tc2_end");

      $display("[TB] backpressure and full-queue stall");
      io_degree         = 3'd4;
      io_prefetch_ready = 1'b0;
      trigger(40'h00_8000_3000, 2'b00);
      expectIdle("t4_lat");
      for (int i = 0; i < 10; i++) expectIssue("t4_hold", 40'h00_8000_3040, CMD_READ);
      io_mshr_avail = 1'b0;
      expectIdle("t4_noavail");
      io_mshr_avail = 1'b1;
      expectIssue("t4_back", 40'h00_8000_3040, CMD_READ);
      trigger(40'h00_8000_5000, 2'b00);
      for (int i = 0; i < 3; i++) expectIssue("t4_stall", 40'h00_8000_3040, CMD_READ);
      io_prefetch_ready = 1'b1;
      for (int i = 0; i < 4; i++) expectIssue("t4_a", 40'h00_8000_3040 + 40'(i * 64), CMD_READ);
      for (int i = 0; i < 4; i++) expectIssue("t4_b", 40'h00_8000_5040 + 40'(i * 64), CMD_READ);
      expectIdle("t4_end");
      expectIdle("t4_end2");

      $display("[TB] restart mid-sequence");
      io_prefetch_ready = 1'b0;
      trigger(40'h00_8000_6000, 2'b00);
      expectIdle("t5a_lat");
      applyStimulus(1'b1, 40'h00_8000_7000, 2'b00);
      expectIssue("t5a_re", 40'h00_8000_6040, CMD_READ);
      applyStimulus(1'b0, 40'd0, 2'd0);
      for (int i = 0; i < 4; i++) expectIssue("t5a_hold", 40'h00_8000_6040, CMD_READ);
      io_prefetch_ready = 1'b1;
      expectIssue("t5a_0", 40'h00_8000_6040, CMD_READ);
      for (int i = 0; i < 4; i++) expectIssue("t5a_n", 40'h00_8000_7040 + 40'(i * 64), CMD_READ);
      expectIdle("t5a_end");
      expectIdle("t5a_end2");

      $display("[TB] duplicate trigger");
      trigger(40'h00_8000_8000, 2'b00);
      applyStimulus(1'b1, 40'h00_8000_8030, 2'b10);
      expectIdle("t5b_lat");
      applyStimulus(1'b0, 40'd0, 2'd0);
      for (int i = 0; i < 4; i++) expectIssue("t5b", 40'h00_8000_8040 + 40'(i * 64), CMD_READ);
      expectIdle("t5b_end");

      $display("[TB] flush");
      io_prefetch_ready = 1'b0;
      io_degree         = 3'd3;
      trigger(40'h00_8000_9000, 2'b00);
      expectIdle("t5c_lat");
      for (int i = 0; i < 3; i++) expectIssue("t5c_fill", 40'h00_8000_9040, CMD_READ);
      io_flush          = 1'b1;
      io_prefetch_ready = 1'b1;
      applyStimulus(1'b1, 40'h00_8000_A000, 2'b00);
      expectIssue("t5c_fcyc", 40'h00_8000_9040, CMD_READ);
      io_flush = 1'b0;
      applyStimulus(1'b0, 40'd0, 2'd0);
      for (int i = 0; i < 3; i++) expectIdle("t5c_gone");
      trigger(40'h00_8000_9000, 2'b00);
      expectIdle("t5c_lat2");
      for (int i = 0; i < 3; i++) expectIssue("t5c_re", 40'h00_8000_9040 + 40'(i * 64), CMD_READ);
      expectIdle("t5c_end");

      $display("[TB] async reset mid-sequence");
      io_prefetch_ready = 1'b0;
      io_degree         = 3'd4;
      trigger(40'h00_8000_B000, 2'b00);
      expectIdle("t6_lat");
      expectIssue("t6_pre", 40'h00_8000_B040, CMD_READ);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("t6_rst/valid", 64'(io_prefetch_valid), 64'd0);
      checkOutput("t6_rst/addr", 64'(io_prefetch_bits_addr), 64'd0);
      checkOutput("t6_rst/cmd", 64'(io_prefetch_bits_uop_mem_cmd), 64'd0);
      tick();
      reset             = 1'b0;
      io_prefetch_ready = 1'b1;
      for (int i = 0; i < 4; i++) expectIdle("t6_quiet");
      trigger(40'h00_8000_B000, 2'b00);
      expectIdle("t6_lat2");
      for (int i = 0; i < 4; i++) expectIssue("t6_re", 40'h00_8000_B040 + 40'(i * 64), CMD_READ);
      expectIdle("t6_end");

      $display("[TB] random triggers");
      mLastTrig  = 40'h00_8000_B000;
      mLastValid = 1'b1;
      for (int n = 0; n < 40; n++) begin
         kind = int'($urandom_range(0, 5));
         case (kind)
            0:       addr = WIN_BASE + 40'($urandom & 32'h7FFF_FFFF);
            1:       addr = WIN_BASE + 40'($urandom & 32'h7FFF_F000) + 40'($urandom_range(32'hF00, 32'hFFF));
            2:       addr = 40'h01_7FFF_F000 + 40'($urandom_range(0, 32'hFFF));
            3:       addr = 40'h00_7FFF_F000 + 40'($urandom_range(0, 32'hFFF));
            4:       addr = mLastTrig + 40'($urandom_range(0, 63));
            default: addr = {8'($urandom_range(0, 255)), 32'($urandom)};
         endcase
         deg  = int'($urandom_range(0, 7));
         coh  = 2'($urandom_range(0, 3));
         line = {addr[39:6], 6'b0};
         if (deg != 0 && (!mLastValid || line != mLastTrig)) begin
            mLastTrig  = line;
            mLastValid = 1'b1;
            buildExpected(addr, deg, coh);
         end

         io_degree = 3'(deg);
         applyStimulus(1'b1, addr, coh);
         holdPending = 1'b0;
         heldAddr    = 40'd0;
         idle        = 0;
         done        = 1'b0;
         for (int c = 0; c < 120 && !done; c++) begin
            io_prefetch_ready = ($urandom_range(0, 3) != 0);
            io_mshr_avail     = ($urandom_range(0, 4) != 0);
            #1;
            if (!io_mshr_avail)
               checkOutput("rnd_avail", 64'(io_prefetch_valid), 64'd0);
            if (io_prefetch_valid && holdPending)
               checkOutput("rnd_hold", 64'(io_prefetch_bits_addr), 64'(heldAddr));
            if (io_prefetch_valid && io_prefetch_ready) begin
               if (expQ.size() == 0) begin
                  checkOutput("rnd_extra", 64'(io_prefetch_valid), 64'd0);
               end else begin
                  checkOutput("rnd_addr", 64'(io_prefetch_bits_addr), 64'(expQ[0].addr));
                  checkOutput("rnd_cmd", 64'(io_prefetch_bits_uop_mem_cmd), 64'(expQ[0].cmd));
                  void'(expQ.pop_front());
               end
               holdPending = 1'b0;
            end else if (io_prefetch_valid) begin
               holdPending = 1'b1;
               heldAddr    = io_prefetch_bits_addr;
            end
            tick();
            if (c == 0) applyStimulus(1'b0, 40'd0, 2'd0);
            if (expQ.size() == 0) idle++;
            if (idle >= 6) done = 1'b1;
         end
         if (!done) checkOutput("rnd_timeout", 64'(expQ.size()), 64'd0);
         expQ.delete();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
